// File: rtl/ld_st_shift_reg_pkg.sv
// ld_st_pkg: shared encodings for the load/store shift register.
//   op_e    - shift command opcodes carried on cmd_op
//   state_e - controller states (IDLE accepts loads/commands, SHIFT runs steps)
package ld_st_pkg;

    typedef enum logic [1:0] {
        OP_SHL = 2'b00,
        OP_SHR = 2'b01,
        OP_ASR = 2'b10,
        OP_ROL = 2'b11
    } op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/ld_st_shift_reg_if.sv
// ld_st_shift_reg_if: data, control and command-handshake bundle of the shift register.
//   master modport: the side that loads/commands the register and watches its status
//   slave  modport: the register itself
//   slIn/LD_ST/set/clr  parallel load and legacy active-low set/clear
//   cmd_*/ser_in        shift command handshake and serial fill bit
//   cmd_ready/busy/done/ser_out/slOut  status and contents
interface ld_st_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
);
    logic [WIDTH-1:0] slIn;
    logic             LD_ST;
    logic             set;
    logic             clr;
    logic             cmd_valid;
    logic [1:0]       cmd_op;
    logic [AMT_W-1:0] cmd_amt;
    logic             ser_in;
    logic             cmd_ready;
    logic             busy;
    logic             done;
    logic             ser_out;
    logic [WIDTH-1:0] slOut;

    modport master (
        output slIn, LD_ST, set, clr, cmd_valid, cmd_op, cmd_amt, ser_in,
        input  cmd_ready, busy, done, ser_out, slOut
    );

    modport slave (
        input  slIn, LD_ST, set, clr, cmd_valid, cmd_op, cmd_amt, ser_in,
        output cmd_ready, busy, done, ser_out, slOut
    );
endinterface

// File: rtl/ld_st_shift_reg_step.sv
// ld_st_shift_step: combinational single-bit shifter.
//   r       current register value
//   op      shift operation
//   ser_in  fill bit for SHL/SHR
//   r_next  value after one step
//   bit_out bit leaving the register on this step
module ld_st_shift_step
    import ld_st_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] r,
    input  op_e              op,
    input  logic             ser_in,
    output logic [WIDTH-1:0] r_next,
    output logic             bit_out
);

    // One shift/rotate step selected by the latched opcode
    always_comb begin
        r_next  = r;
        bit_out = 1'b0;
        case (op)
            OP_SHL: begin
                r_next  = {r[WIDTH-2:0], ser_in};
                bit_out = r[WIDTH-1];
            end
            OP_SHR: begin
                r_next  = {ser_in, r[WIDTH-1:1]};
                bit_out = r[0];
            end
            OP_ASR: begin
                r_next  = {r[WIDTH-1], r[WIDTH-1:1]};
                bit_out = r[0];
            end
            OP_ROL: begin
                r_next  = {r[WIDTH-2:0], r[WIDTH-1]};
                bit_out = r[WIDTH-1];
            end
            default: begin
                r_next  = r;
                bit_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ld_st_shift_reg.sv
// ld_st_shift_reg: WIDTH-bit datapath register with legacy active-low set/clr,
// single-cycle parallel load and multi-cycle SHL/SHR/ASR/ROL commands (one bit per clock).
//   clk  clock, all state changes on the rising edge
//   rst  synchronous active-high reset, dominates everything
//   bus  ld_st_shift_reg_if slave: load/set/clr inputs, command handshake, status, contents
module ld_st_shift_reg
    import ld_st_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    ld_st_shift_reg_if.slave    bus
);

    localparam logic [AMT_W-1:0] CNT_ZERO = {AMT_W{1'b0}};
    localparam logic [AMT_W-1:0] CNT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};

    state_e           state_r;
    op_e              op_r;
    logic [AMT_W-1:0] cnt_r;
    logic [WIDTH-1:0] sl_r;
    logic             done_r;
    logic             ser_out_r;
    logic             cmd_ready_s;
    logic [WIDTH-1:0] step_next_s;
    logic             step_bit_s;

    ld_st_shift_step #(.WIDTH(WIDTH)) u_step (
        .r       (sl_r),
        .op      (op_r),
        .ser_in  (bus.ser_in),
        .r_next  (step_next_s),
        .bit_out (step_bit_s)
    );

    // Commands are only taken when nothing of higher priority (reset, clr, set, load) acts this edge
    assign cmd_ready_s = (state_r == IDLE) & bus.set & bus.clr & ~bus.LD_ST & ~rst;

    // Controller FSM together with the register, counter, op latch and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            op_r      <= OP_SHL;
            cnt_r     <= CNT_ZERO;
            sl_r      <= {WIDTH{1'b0}};
            done_r    <= 1'b0;
            ser_out_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (!bus.clr) begin
                // clr/set abort any running command silently; ser_out keeps its value
                sl_r    <= {WIDTH{1'b0}};
                state_r <= IDLE;
                cnt_r   <= CNT_ZERO;
            end else if (!bus.set) begin
                sl_r    <= {WIDTH{1'b1}};
                state_r <= IDLE;
                cnt_r   <= CNT_ZERO;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (bus.LD_ST) begin
                            sl_r <= bus.slIn;
                        end else if (bus.cmd_valid && cmd_ready_s) begin
                            op_r <= op_e'(bus.cmd_op);
                            if (bus.cmd_amt == CNT_ZERO) begin
                                // zero-length command completes immediately without touching data
                                done_r <= 1'b1;
                            end else begin
                                cnt_r   <= bus.cmd_amt;
                                state_r <= SHIFT;
                            end
                        end else begin
                            sl_r <= sl_r;
                        end
                    end
                    SHIFT: begin
                        sl_r      <= step_next_s;
                        ser_out_r <= step_bit_s;
                        cnt_r     <= cnt_r - CNT_ONE;
                        if (cnt_r == CNT_ONE) begin
                            state_r <= IDLE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= SHIFT;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        cnt_r   <= CNT_ZERO;
                    end
                endcase
            end
        end
    end

    assign bus.cmd_ready = cmd_ready_s;
    assign bus.busy      = (state_r == SHIFT);
    assign bus.done      = done_r;
    assign bus.ser_out   = ser_out_r;
    assign bus.slOut     = sl_r;

endmodule
